// File: rtl/nv_nvdla_sdp_erdma_flopram_rwsa_mxn.sv
// DEPTH-entry flop register file with one write and one read port, a post-reset clear sequencer and a write-data bypass at ra==DEPTH.
// Define NV_SDP_FLOPRAM_DOUT_REG_EN to register dout, which gives 1-cycle read latency.
module nv_nvdla_sdp_erdma_flopram_rwsa_mxn #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int AW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pwrbus_ram_pd,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] di,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] dout,
    output logic             init_busy,
    output logic             err_wr_drop
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [IW-1:0]     mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic              wr_drop;
    logic [WIDTH-1:0]  rd_data;
    logic              unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;
    assign init_busy     = (state == INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && clr_ptr == LAST_A) begin
            state_nxt = IDLE;
        end
    end

    // The clear sequencer owns the write port until it finishes; user writes then are dropped.
    assign wr_drop = we & (init_busy | (wa >= DEPTH_A));
    assign mem_we  = init_busy | (we & (wa < DEPTH_A));
    assign mem_wa  = init_busy ? clr_ptr[IW-1:0] : wa[IW-1:0];
    assign mem_wd  = init_busy ? '0 : di;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_wr_drop <= 1'b0;
        end else if (wr_drop) begin
            err_wr_drop <= 1'b1;
        end
    end

    // Reads see pre-write contents; only ra==DEPTH forwards di.
    always_comb begin
        rd_data = '0;
        if (ra < DEPTH_A) begin
            if (!init_busy) begin
                rd_data = mem[ra[IW-1:0]];
            end
        end else if (ra == DEPTH_A) begin
            rd_data = di;
        end
    end

`ifdef NV_SDP_FLOPRAM_DOUT_REG_EN
    logic [WIDTH-1:0] dout_p1;

    // Stage p1: registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_p1 <= '0;
        end else begin
            dout_p1 <= rd_data;
        end
    end

    assign dout = dout_p1;
`else
    assign dout = rd_data;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_erdma_flopram_rwsa_mxn.sv
// Self-checking bench for the flop register file: vector tables fed through a latency-aware scoreboard plus reset/clear corner sequences.
module tb_nv_nvdla_sdp_erdma_flopram_rwsa_mxn;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
`ifdef NV_SDP_FLOPRAM_DOUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      pwrbus_ram_pd;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] di;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] dout;
    logic             init_busy;
    logic             err_wr_drop;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             chk;
        logic             we;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] di;
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] dout;
        logic             busy;
        logic             err;
    } vec_t;

    typedef struct {
        logic             chk;
        logic [WIDTH-1:0] exp;
        string            name;
    } sb_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    sb_t  sb[$];

    nv_nvdla_sdp_erdma_flopram_rwsa_mxn #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pwrbus_ram_pd(pwrbus_ram_pd),
        .we(we),
        .wa(wa),
        .di(di),
        .ra(ra),
        .dout(dout),
        .init_busy(init_busy),
        .err_wr_drop(err_wr_drop)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic chk, input logic w, input logic [AW-1:0] a,
                                input logic [WIDTH-1:0] d, input logic [AW-1:0] r,
                                input logic [WIDTH-1:0] q, input logic b, input logic e);
        vec_t v;
        v.chk = chk; v.we = w; v.wa = a; v.di = d; v.ra = r;
        v.dout = q; v.busy = b; v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input vec_t v, input string name);
        sb_t e;
        we = v.we; wa = v.wa; di = v.di; ra = v.ra;
        e.chk = v.chk; e.exp = v.dout; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        check({name, " init_busy"}, WIDTH'(init_busy), WIDTH'(v.busy));
        check({name, " err_wr_drop"}, WIDTH'(err_wr_drop), WIDTH'(v.err));
        if (sb.size() > LAT) begin
            e = sb.pop_front();
            if (e.chk) check({e.name, " dout"}, dout, e.exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; wa = '0; di = '0; ra = '0;
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset init_busy", WIDTH'(init_busy), WIDTH'(1));
        check("reset err_wr_drop", WIDTH'(err_wr_drop), WIDTH'(0));
`ifdef NV_SDP_FLOPRAM_DOUT_REG_EN
        check("reset dout", dout, '0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b1; pwrbus_ram_pd = '0; we = 1'b0; wa = '0; di = '0; ra = '0;

        // chk, we, wa, di, ra, dout, busy, err
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h1234_5678, 4, 32'h1234_5678, 1, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 7, 32'h0000_0000, 1, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 3, 32'h0000_0000, 1, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 2, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 3, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 1, 2, 32'hA5A5_A5A5, 2, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 2, 32'hA5A5_A5A5, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 1, 1, 32'h0000_0011, 1, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 1, 32'h0000_0011, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0077, 4, 32'h0000_0077, 0, 0));
        tbl_a.push_back(mk(1, 1, 3, 32'h0000_0099, 4, 32'h0000_0099, 0, 0));
        tbl_a.push_back(mk(1, 1, 5, 32'hDEAD_BEEF, 6, 32'h0000_0000, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 6, 32'h0000_0000, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 1, 32'h0000_0011, 0, 1));
        tbl_a.push_back(mk(1, 1, 4, 32'hCAFE_F00D, 0, 32'h0000_0000, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 2, 32'hA5A5_A5A5, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 3, 32'h0000_0099, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 5, 32'h0000_0000, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 32'h0000_0000, 7, 32'h0000_0000, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1));

        // Write during the first INIT cycle is dropped and flagged; contents survive a fresh reset as zero.
        tbl_b.push_back(mk(1, 1, 0, 32'h0000_00FF, 0, 32'h0000_0000, 1, 0));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 2, 32'h0000_0000, 0, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0000, 3, 32'h0000_0000, 0, 1));
        tbl_b.push_back(mk(1, 0, 0, 32'h0000_0077, 4, 32'h0000_0077, 0, 1));
        tbl_b.push_back(mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1));

        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < tbl_a.size(); i++) step(tbl_a[i], $sformatf("A%0d", i));

        do_reset();
        for (int i = 0; i < tbl_b.size(); i++) step(tbl_b[i], $sformatf("B%0d", i));

        // Reset reasserted in INIT cycle 2 restarts the full clear.
        do_reset();
        step(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 0), "C0");
        reset = 1'b1;
        @(negedge clk);
        check("C1 init_busy", WIDTH'(init_busy), WIDTH'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (init_busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check("C restart busy cycles", WIDTH'(busy_cnt), WIDTH'(DEPTH));
        check("C err after reset", WIDTH'(err_wr_drop), WIDTH'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
